// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control sequencer.
// Opcode and funct values follow the MIPS-I encoding used by mips.h.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    REXEC  = 4'd7,
    IEXEC  = 4'd8,
    ALUWB  = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    SYSC   = 4'd12,
    TRAP   = 4'd13
  } stateT;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [2:0] ALU_LUI = 3'b011;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_SLT     = 6'b101010;

  // Successor of DECODE; the all-zero word is a NOP that retires immediately.
  function automatic stateT decodeDispatch(input logic [31:0] inst);
    stateT nxt;
    nxt = TRAP;
    if (inst == 32'd0) begin
      nxt = FETCH;
    end else begin
      case (inst[31:26])
        OP_RTYPE: begin
          case (inst[5:0])
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: nxt = REXEC;
            FN_JR:                                 nxt = JUMP;
            FN_SYSCALL:                            nxt = SYSC;
            default:                               nxt = TRAP;
          endcase
        end
        OP_LW, OP_SW:                      nxt = MEMADR;
        OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: nxt = IEXEC;
        OP_BEQ, OP_BNE:                    nxt = BRANCH;
        OP_J, OP_JAL:                      nxt = JUMP;
        default:                           nxt = TRAP;
      endcase
    end
    return nxt;
  endfunction

  function automatic logic [2:0] rAluOp(input logic [5:0] funct);
    logic [2:0] op;
    case (funct)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [2:0] iAluOp(input logic [5:0] opcode);
    logic [2:0] op;
    case (opcode)
      OP_ORI:  op = ALU_OR;
      OP_LUI:  op = ALU_LUI;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready; timeout flags that the budget is used up.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [TMR_W-1:0] count;

  assign timeout = (count == TMR_W'(MEM_TIMEOUT));

  // Holding at the limit keeps the counter from wrapping when MEM_TIMEOUT is the max value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !timeout) begin
      count <= count + TMR_W'(1);
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control sequencer: steps each instruction through the shared
// datapath and guards every memory wait with a timeout that traps.
//   state  | meaning
//   IDLE   | one cycle after reset, all outputs low
//   FETCH  | read instruction at PC, load IR and PC+4 on mem_ready
//   DECODE | branch target into ALUOut, dispatch on opcode/funct
//   MEMADR | compute load/store address
//   MEMRD  | load read, wait mem_ready
//   MEMWB  | write MDR to rt
//   MEMWR  | store write, wait mem_ready
//   REXEC  | R-type ALU op
//   IEXEC  | immediate ALU op
//   ALUWB  | write ALUOut to rd/rt
//   BRANCH | compare and conditionally load PC
//   JUMP   | j / jal / jr
//   SYSC   | syscall handshake
//   TRAP   | illegal instruction or memory timeout, absorbing
module mc_control import mips_ctrl_pkg::*; #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        inst,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               syscall_done,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemToReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUOp,
  output logic [1:0]         PCSource,
  output logic               jal_link,
  output logic               syscall_req,
  output logic               retired,
  output logic               trap,
  output logic [STATE_W-1:0] dbg_state
);

  stateT      state, nextState;
  logic       regDstQ;
  logic       waitState, tmrTimeout;
  logic [5:0] opcode, funct;

  assign opcode    = inst[31:26];
  assign funct     = inst[5:0];
  assign dbg_state = STATE_W'(state);
  assign waitState = (state == FETCH) || (state == MEMRD) || (state == MEMWR);

  // Leaving a wait state only happens on mem_ready, so clearing then gives every entry a fresh count.
  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) uWaitTimer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!waitState || mem_ready),
    .enable (waitState && !mem_ready),
    .timeout(tmrTimeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      regDstQ <= 1'b0;
    end else begin
      state <= nextState;
      if (state == REXEC) regDstQ <= 1'b1;
      else if (state == IEXEC) regDstQ <= 1'b0;
    end
  end

  always_comb begin
    nextState   = state;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    ALUOp       = ALU_AND;
    PCSource    = PCSRC_ALU;
    jal_link    = 1'b0;
    syscall_req = 1'b0;
    retired     = 1'b0;
    trap        = 1'b0;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          PCWrite   = 1'b1;
          ALUSrcB   = SRCB_FOUR;
          ALUOp     = ALU_ADD;
          PCSource  = PCSRC_ALU;
          nextState = DECODE;
        end else if (tmrTimeout) begin
          nextState = TRAP;
        end
      end
      DECODE: begin
        ALUSrcB   = SRCB_IMMSH;
        ALUOp     = ALU_ADD;
        retired   = (inst == 32'd0);
        nextState = decodeDispatch(inst);
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = ALU_ADD;
        nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) nextState = MEMWB;
        else if (tmrTimeout) nextState = TRAP;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemToReg  = 1'b1;
        retired   = 1'b1;
        nextState = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retired   = 1'b1;
          nextState = FETCH;
        end else if (tmrTimeout) begin
          nextState = TRAP;
        end
      end
      REXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_RT;
        ALUOp     = rAluOp(funct);
        nextState = ALUWB;
      end
      IEXEC: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_IMM;
        ALUOp     = iAluOp(opcode);
        nextState = ALUWB;
      end
      ALUWB: begin
        RegWrite  = 1'b1;
        RegDst    = regDstQ;
        retired   = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_RT;
        ALUOp     = ALU_SUB;
        PCSource  = PCSRC_ALUOUT;
        PCWrite   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        retired   = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        retired = 1'b1;
        if (opcode == OP_RTYPE) begin
          PCSource = PCSRC_RS;
        end else begin
          PCSource = PCSRC_JUMP;
          RegWrite = (opcode == OP_JAL);
          jal_link = (opcode == OP_JAL);
        end
        nextState = FETCH;
      end
      SYSC: begin
        syscall_req = 1'b1;
        if (syscall_done) begin
          retired   = 1'b1;
          nextState = FETCH;
        end
      end
      TRAP: trap = 1'b1;
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
Multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through fetch, decode, execute, memory and writeback states, and waits on a memory-ready handshake with a parametrised timeout. It drives the shared-datapath muxes, the register-file write enables and the syscall handshake. It sits between the instruction register / memory interface and the multi-cycle datapath.

Parameters:
MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready in any memory state before trapping (1..2^TMR_W-1).
TMR_W, 4, width of the wait-cycle counter.
STATE_W, 4, width of the state encoding exported on dbg_state.

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst_n  in  1  asynchronous active-low reset
inst  in  32  instruction register contents; stable outside FETCH
zero  in  1  ALU zero flag, valid in BRANCH
mem_ready  in  1  memory completes the access this cycle
syscall_done  in  1  host has serviced the syscall
PCWrite  out  1  PC load enable
IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  destination select: 0 = rt, 1 = rd
MemToReg  out  1  write-back data select: 0 = ALUOut, 1 = MDR
RegWrite  out  1  register file write enable
ALUSrcA  out  1  ALU A select: 0 = PC, 1 = rs
ALUSrcB  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign/zero-extended imm, 11 = imm<<2
ALUOp  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 lui
PCSource  out  2  PC mux select: 00 = ALU, 01 = ALUOut (branch), 10 = jump target, 11 = rs (jr)
jal_link  out  1  force write-back register to 31 and data to PC
syscall_req  out  1  syscall request, held high until syscall_done
retired  out  1  one-cycle pulse on instruction completion
trap  out  1  sticky illegal-instruction or memory-timeout flag
dbg_state  out  STATE_W  current state encoding

Behaviour:
- Reset (rst_n low, async): state = IDLE, timer = 0, trap = 0. Every output is 0.
- IDLE: all outputs 0. The next cycle goes to FETCH. Total latency after reset release to first fetch = 1 cycle.
- FETCH: MemRead = 1, IorD = 0 held until mem_ready.
  - In the mem_ready cycle also IRWrite = 1, PCWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 010, PCSource = 00.
  - Next state is DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 11, ALUOp = 010 (branch target into ALUOut). Dispatch on inst[31:26] / inst[5:0]:
  - LW or SW -> MEMADR
  - ADD, SUB, AND, OR, SLT -> REXEC
  - ADDI, ADDIU, ORI, LUI -> IEXEC
  - BEQ or BNE -> BRANCH
  - J, JAL, JR -> JUMP
  - SYSCALL -> SYSC
  - all-zero word (NOP) -> FETCH with retired = 1
  - anything else -> TRAP
- MEMADR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 010. Goes to MEMRD (LW) or MEMWR (SW).
- MEMRD: MemRead = 1, IorD = 1 held until mem_ready, then MEMWB.
- MEMWB: RegWrite = 1, MemToReg = 1, RegDst = 0, retired = 1. Goes to FETCH.
- MEMWR: MemWrite = 1, IorD = 1 held until mem_ready. In the ready cycle retired = 1. Goes to FETCH.
- REXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp from funct. Goes to ALUWB with RegDst = 1.
- IEXEC: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 010 / 001 / 011. Goes to ALUWB with RegDst = 0.
- ALUWB: RegWrite = 1, MemToReg = 0, RegDst as latched, retired = 1. Goes to FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 110, PCSource = 01.
  - PCWrite = (BEQ & zero) | (BNE & ~zero).
  - retired = 1. Goes to FETCH.
- JUMP:
  - J: PCSource = 10, PCWrite = 1.
  - JAL: same as J plus RegWrite = 1, jal_link = 1.
  - JR: PCSource = 11, PCWrite = 1, RegWrite = 0.
  - retired = 1. Goes to FETCH.
- SYSC: syscall_req = 1 until syscall_done is sampled high. That same cycle retired = 1, then FETCH. There is no timeout in SYSC.
- Timer:
  - Cleared on entry to FETCH, MEMRD and MEMWR.
  - Increments each cycle mem_ready = 0 in those states.
  - When the timer equals MEM_TIMEOUT with mem_ready still 0, go to TRAP.
  - mem_ready high in the same cycle the timer reaches MEM_TIMEOUT means success; the ready wins.
- TRAP: trap = 1, all other outputs 0, absorbing until rst_n is asserted.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored. syscall_done outside SYSC is ignored.
- Outputs are combinational from state, latched decode bits, mem_ready and zero. There is no output register.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state enum (IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REXEC, IEXEC, ALUWB, BRANCH, JUMP, SYSC, TRAP)
  - ALUOp codes
  - ALUSrcB / PCSource codes
  - opcode/funct constants mirroring mips.h
- One sub-module: mem_wait_timer (clear, enable, timeout output; parameters MEM_TIMEOUT and TMR_W).

Test Plan:
- Reset release, ADD word, mem_ready = 1 always -> IDLE, FETCH, DECODE, REXEC, ALUWB. ALUOp = 010, RegDst = 1, RegWrite = 1, retired = 1 in cycle 5.
- LW with mem_ready low for 3 cycles in MEMRD -> MemRead and IorD held for 4 cycles; MEMWB with MemToReg = 1; trap = 0.
- BEQ with zero = 1, then BNE with zero = 1 -> PCWrite = 1 then 0. PCSource = 01 in both BRANCH cycles.
- JAL, then JR -> JAL: PCSource = 10, RegWrite = 1, jal_link = 1. JR: PCSource = 11, RegWrite = 0.
- SW with mem_ready never asserted, MEM_TIMEOUT = 15 -> TRAP reached 15 cycles after MEMWR entry. trap stays 1 until rst_n low, which clears it asynchronously.
- SYSCALL, syscall_done after 5 cycles; opcode 6'b111111 -> syscall_req high 6 cycles, then FETCH. The illegal opcode goes to TRAP from DECODE.
